// File: rtl/bsg_manycore_link_sdr_reset_sequencer.sv
// bsg_manycore_link_sdr_reset_sequencer
//
// Purpose: drives the four SDR link resets (uplink, downlink, downstream,
// token) in the order the link needs. The sequence runs once when core reset
// is released and runs again on request. Every output comes straight from its
// own flop, so the link clock domain can sample it asynchronously without
// seeing a glitch.
//
// Ports:
//   core_clk_i                in   1  sole clock
//   core_reset_i              in   1  synchronous, active-high reset
//   restart_i                 in   1  1-cycle request to re-run the sequence
//   async_uplink_reset_o      out  1  to link async_uplink_reset_i
//   async_downlink_reset_o    out  1  to link async_downlink_reset_i
//   async_downstream_reset_o  out  1  to link async_downstream_reset_i
//   async_token_reset_o       out  1  to link async_token_reset_i
//   done_o                    out  1  sequence complete, link usable
//   state_o                   out  3  current state (BSG_SDR_RESET_SEQ_STATUS_EN only)
//
// Optional feature macro: BSG_SDR_RESET_SEQ_STATUS_EN adds state_o and a
// simulation check that at most one reset output changes on a normal advance.

module bsg_manycore_link_sdr_reset_sequencer #(
   parameter int unsigned hold_cycles_p  = 16,
   parameter int unsigned token_cycles_p = 8,
   parameter int unsigned gap_cycles_p   = 32
) (
   input  logic       core_clk_i,
   input  logic       core_reset_i,
   input  logic       restart_i,
   output logic       async_uplink_reset_o,
   output logic       async_downlink_reset_o,
   output logic       async_downstream_reset_o,
   output logic       async_token_reset_o,
   output logic       done_o
`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
   ,
   output logic [2:0] state_o
`endif
);

   localparam int unsigned max_ht_lp    = (hold_cycles_p > token_cycles_p) ? hold_cycles_p : token_cycles_p;
   localparam int unsigned max_lp       = (max_ht_lp > gap_cycles_p) ? max_ht_lp : gap_cycles_p;
   localparam int unsigned ctr_width_lp = ($clog2(max_lp + 1) < 1) ? 1 : $clog2(max_lp + 1);

   // Last counter value in each dwell; the FSM advances when it is reached.
   localparam logic [ctr_width_lp-1:0] hold_last_lp  = ctr_width_lp'(hold_cycles_p - 1);
   localparam logic [ctr_width_lp-1:0] token_last_lp = ctr_width_lp'(token_cycles_p - 1);
   localparam logic [ctr_width_lp-1:0] gap_last_lp   = ctr_width_lp'(gap_cycles_p - 1);

   typedef enum logic [2:0] {
      e_all    = 3'd0,
      e_tok_hi = 3'd1,
      e_tok_lo = 3'd2,
      e_up_rel = 3'd3,
      e_dn_rel = 3'd4,
      e_ds_rel = 3'd5,
      e_done   = 3'd6
   } state_e;

   // Output decode per state, packed as {uplink, downlink, downstream, token, done}.
   function automatic logic [4:0] f_decode(input state_e s);
      logic [4:0] v;
      case (s)
         e_all:    v = 5'b11100;
         e_tok_hi: v = 5'b11110;
         e_tok_lo: v = 5'b11100;
         e_up_rel: v = 5'b01100;
         e_dn_rel: v = 5'b00100;
         e_ds_rel: v = 5'b00000;
         e_done:   v = 5'b00001;
         default:  v = 5'b11100;
      endcase
      return v;
   endfunction

   state_e                  r_state;
   logic [ctr_width_lp-1:0] r_ctr;
   logic                    r_uplink;
   logic                    r_downlink;
   logic                    r_downstream;
   logic                    r_token;
   logic                    r_done;

   logic                    w_last;
   state_e                  w_adv_state;
   state_e                  w_next_state;
   logic [ctr_width_lp-1:0] w_next_ctr;
   logic [4:0]              w_next_out;

   // Dwell-end detection, successor state and next counter value.
   always_comb begin
      w_last      = 1'b0;
      w_adv_state = r_state;
      case (r_state)
         e_all:    begin w_last = (r_ctr == hold_last_lp);  w_adv_state = e_tok_hi; end
         e_tok_hi: begin w_last = (r_ctr == token_last_lp); w_adv_state = e_tok_lo; end
         e_tok_lo: begin w_last = (r_ctr == gap_last_lp);   w_adv_state = e_up_rel; end
         e_up_rel: begin w_last = (r_ctr == gap_last_lp);   w_adv_state = e_dn_rel; end
         e_dn_rel: begin w_last = (r_ctr == gap_last_lp);   w_adv_state = e_ds_rel; end
         e_ds_rel: begin w_last = (r_ctr == gap_last_lp);   w_adv_state = e_done;   end
         e_done:   begin w_last = 1'b0;                     w_adv_state = e_done;   end
         // Unused encoding: fall back to the start of the sequence.
         default:  begin w_last = 1'b1;                     w_adv_state = e_all;    end
      endcase

      if (restart_i)
         w_next_state = e_all;
      else if (w_last)
         w_next_state = w_adv_state;
      else
         w_next_state = r_state;

      // Counter clears on every state entry and parks at zero in DONE.
      if (restart_i || w_last || (r_state == e_done))
         w_next_ctr = '0;
      else
         w_next_ctr = r_ctr + 1'b1;

      w_next_out = f_decode(w_next_state);
   end

   // State, counter and output flops; outputs load the next state's decode.
   always_ff @(posedge core_clk_i) begin
      if (core_reset_i) begin
         r_state <= e_all;
         r_ctr   <= '0;
         {r_uplink, r_downlink, r_downstream, r_token, r_done} <= f_decode(e_all);
      end else begin
         r_state <= w_next_state;
         r_ctr   <= w_next_ctr;
         {r_uplink, r_downlink, r_downstream, r_token, r_done} <= w_next_out;
      end
   end

   assign async_uplink_reset_o     = r_uplink;
   assign async_downlink_reset_o   = r_downlink;
   assign async_downstream_reset_o = r_downstream;
   assign async_token_reset_o      = r_token;
   assign done_o                   = r_done;

`ifdef BSG_SDR_RESET_SEQ_STATUS_EN
   assign state_o = r_state;

   // Normal advances move exactly one reset line; reset/restart may move several.
   always_ff @(posedge core_clk_i) begin
      if (!core_reset_i && !restart_i && w_last)
         assert ($countones(w_next_out[4:1] ^ {r_uplink, r_downlink, r_downstream, r_token}) <= 1);
   end
`endif

endmodule

// File: tb/tb_bsg_manycore_link_sdr_reset_sequencer.sv
module tb_bsg_manycore_link_sdr_reset_sequencer;

   localparam int unsigned H     = 4;
   localparam int unsigned T     = 2;
   localparam int unsigned G     = 3;
   localparam int unsigned TOTAL = H + T + 4 * G;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_s     = 1'b1;
   logic restart_s = 1'b0;
   logic up, dn, ds, tok, done;

   logic d_rst     = 1'b1;
   logic d_restart = 1'b0;
   logic d_up, d_dn, d_ds, d_tok, d_done;

   bsg_manycore_link_sdr_reset_sequencer #(
      .hold_cycles_p (H),
      .token_cycles_p(T),
      .gap_cycles_p  (G)
   ) dut (
      .core_clk_i              (clk),
      .core_reset_i            (rst_s),
      .restart_i               (restart_s),
      .async_uplink_reset_o    (up),
      .async_downlink_reset_o  (dn),
      .async_downstream_reset_o(ds),
      .async_token_reset_o     (tok),
      .done_o                  (done)
   );

   bsg_manycore_link_sdr_reset_sequencer dut_def (
      .core_clk_i              (clk),
      .core_reset_i            (d_rst),
      .restart_i               (d_restart),
      .async_uplink_reset_o    (d_up),
      .async_downlink_reset_o  (d_dn),
      .async_downstream_reset_o(d_ds),
      .async_token_reset_o     (d_tok),
      .done_o                  (d_done)
   );

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int unsigned t = 0;   // model: cycles elapsed since the sequence (re)started

   // Reference: outputs as a function of elapsed time {up,dn,ds,tok,done}.
   function automatic logic [4:0] mdl(input int unsigned tt);
      logic [4:0] v;
      v[4] = (tt < H + T + G);
      v[3] = (tt < H + T + 2 * G);
      v[2] = (tt < H + T + 3 * G);
      v[1] = (tt >= H) && (tt < H + T);
      v[0] = (tt >= TOTAL);
      return v;
   endfunction

   task automatic chk_int(input string nm, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // One cycle: drive inputs at the falling edge, compare this cycle's outputs,
   // then advance the model for the coming rising edge.
   task automatic step(input logic rst, input logic rs, input bit use_exp,
                       input logic [4:0] exp, input string nm);
      logic [4:0] got, want;
      @(negedge clk);
      rst_s     = rst;
      restart_s = rs;
      got  = {up, dn, ds, tok, done};
      want = use_exp ? exp : mdl(t);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, want);
      end
      if (rst || rs)      t = 0;
      else if (t < TOTAL) t = t + 1;
      cyc++;
   endtask

   typedef struct {
      logic       rst;
      logic       rs;
      logic [4:0] exp;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int first_done;
      int tokw;

      // Basic sequence expectations, cycle 0 = first cycle with reset low.
      for (int c = 0; c < 20; c++) begin
         tbl[c].rst = 1'b0;
         tbl[c].rs  = 1'b0;
         tbl[c].exp = 5'b11100;
      end
      for (int c = 4;  c <= 5;  c++) tbl[c].exp = 5'b11110;
      for (int c = 9;  c <= 11; c++) tbl[c].exp = 5'b01100;
      for (int c = 12; c <= 14; c++) tbl[c].exp = 5'b00100;
      for (int c = 15; c <= 17; c++) tbl[c].exp = 5'b00000;
      for (int c = 18; c <= 19; c++) tbl[c].exp = 5'b00001;

      // Power-up reset, then reset held 20 cycles.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rst_s = 1'b1;
      end
      t = 0;
      for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 5'b11100, "reset_hold");

      // Basic sequence from the table.
      cyc = 0;
      for (int c = 0; c < 20; c++) step(tbl[c].rst, tbl[c].rs, 1'b1, tbl[c].exp, "basic_seq");

      // Restart after done at cycle 20.
      step(1'b0, 1'b1, 1'b1, 5'b00001, "restart_done_pre");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "restart_done_all");
      for (int c = 22; c < 38; c++) step(1'b0, 1'b0, 1'b0, '0, "restart_done_model");
      step(1'b0, 1'b0, 1'b1, 5'b00000, "restart_done_c38");
      step(1'b0, 1'b0, 1'b1, 5'b00001, "restart_done_c39");

      // Restart mid-sequence at cycle 10.
      step(1'b1, 1'b0, 1'b0, '0, "mid_reset");
      step(1'b1, 1'b0, 1'b1, 5'b11100, "mid_reset");
      cyc = 0;
      for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0, '0, "mid_model");
      step(1'b0, 1'b1, 1'b1, 5'b01100, "mid_c10");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "mid_c11");
      for (int c = 12; c < 15; c++) step(1'b0, 1'b0, 1'b0, '0, "mid_model");
      step(1'b0, 1'b0, 1'b1, 5'b11110, "mid_tok_c15");
      step(1'b0, 1'b0, 1'b1, 5'b11110, "mid_tok_c16");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "mid_tok_c17");
      for (int c = 18; c < 28; c++) step(1'b0, 1'b0, 1'b0, '0, "mid_model");
      step(1'b0, 1'b0, 1'b1, 5'b00000, "mid_c28");
      step(1'b0, 1'b0, 1'b1, 5'b00001, "mid_done_c29");

      // Reset and restart together at cycle 6.
      step(1'b1, 1'b0, 1'b0, '0, "prio_reset");
      step(1'b1, 1'b0, 1'b1, 5'b11100, "prio_reset");
      cyc = 0;
      for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b0, '0, "prio_model");
      step(1'b1, 1'b1, 1'b1, 5'b11100, "prio_c6");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "prio_c7");
      step(1'b0, 1'b0, 1'b0, '0, "prio_model");
      step(1'b0, 1'b0, 1'b0, '0, "prio_model");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "prio_c10");
      step(1'b0, 1'b0, 1'b1, 5'b11110, "prio_tok_c11");
      step(1'b0, 1'b0, 1'b1, 5'b11110, "prio_tok_c12");
      step(1'b0, 1'b0, 1'b1, 5'b11100, "prio_c13");

      // Randomized reset/restart traffic against the model.
      cyc = 0;
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0), 1'b0, '0, "random");

      // Default-parameter instance: latency to done and token width.
      @(negedge clk);
      rst_s     = 1'b0;
      restart_s = 1'b0;
      chk_int("def_reset_vals", int'({d_up, d_dn, d_ds, d_tok, d_done}), int'(5'b11100));
      d_rst      = 1'b0;
      first_done = -1;
      tokw       = 0;
      for (int c = 0; c < 400 && first_done < 0; c++) begin
         if (c > 0) @(negedge clk);
         if (d_tok)  tokw++;
         if (d_done) first_done = c;
      end
      chk_int("def_done_latency", first_done, 152);
      chk_int("def_token_width", tokw, 8);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
